// File: rtl/tsc_pkg.sv
// TSC bus responder shared types.
// Word width, FSM state codes and request kinds.
package tsc_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE     = 2'd0;
  localparam state_t S_BUSY     = 2'd1;
  localparam state_t S_RESPOND  = 2'd2;
  localparam state_t S_WAIT_REL = 2'd3;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/tsc_mem_array.sv
// Word-addressed storage: one synchronous write port,
// one asynchronous read port.
module tsc_mem_array #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tsc_memory_responder.sv
// Memory-side end of the TSC readM/writeM handshake.
// Answers after LATENCY cycles; drives data only with inputReady.
module tsc_memory_responder #(
  parameter int WORD_SIZE = tsc_pkg::WORD_SIZE,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  input  logic                 load_en,
  input  logic [WORD_SIZE-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 proto_err
);

  import tsc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state;
  logic [3:0]           cnt;
  op_t                  op;
  logic [AW-1:0]        idx;
  logic [WORD_SIZE-1:0] wdat;
  logic                 ir_q;
  logic                 ack_q;
  logic                 perr_q;

  logic                 line;
  logic                 commit;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic                 unused_bits;

  // Only the line of the accepted request matters after IDLE.
  assign line = (op == OP_WRITE) ? writeM : readM;

  assign commit = (state == S_RESPOND) && (op == OP_WRITE);

  assign mem_we = !reset &&
                  (commit || (state == S_IDLE && load_en));

  assign mem_waddr = commit ? idx  : load_addr[AW-1:0];
  assign mem_wdata = commit ? wdat : load_data;

  assign unused_bits = ^{address[WORD_SIZE-1:AW],
                         load_addr[WORD_SIZE-1:AW]};

  tsc_mem_array #(
    .W     (WORD_SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= OP_READ;
      idx    <= '0;
      wdat   <= '0;
      ir_q   <= 1'b0;
      ack_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ir_q  <= 1'b0;
      ack_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (readM || writeM) begin
            op    <= readM ? OP_READ : OP_WRITE;
            idx   <= address[AW-1:0];
            state <= S_BUSY;
            cnt   <= CNT_INIT;
            if (!readM) wdat <= data;
            if (readM && writeM) perr_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!line) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_RESPOND;
            ir_q  <= (op == OP_READ);
            ack_q <= (op == OP_WRITE);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!line) state <= S_IDLE;
        end
      endcase
    end
  end

  assign inputReady = ir_q;
  assign ackOutput  = ack_q;
  assign proto_err  = perr_q;
  assign data       = ir_q ? rdata : 'z;

endmodule

// File: tb/tb_tsc_memory_responder.sv
// Bench: LATENCY=1 and LATENCY=3 responders on shared stimulus,
// checked every cycle against a request/deadline model.
module tb_tsc_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd;
  logic        wr;
  logic        le;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] la;
  logic [15:0] ld;

  wire  [15:0] bus0;
  wire  [15:0] bus1;
  wire  [1:0]  ir;
  wire  [1:0]  ack;
  wire  [1:0]  pe;

  assign bus0 = (wr && !rd && !ir[0]) ? wdata : 'z;
  assign bus1 = (wr && !rd && !ir[1]) ? wdata : 'z;

  tsc_memory_responder #(.LATENCY(1)) u_l1 (
    .clk        (clk),
    .reset      (rst),
    .readM      (rd),
    .writeM     (wr),
    .address    (addr),
    .data       (bus0),
    .inputReady (ir[0]),
    .ackOutput  (ack[0]),
    .load_en    (le),
    .load_addr  (la),
    .load_data  (ld),
    .proto_err  (pe[0])
  );

  tsc_memory_responder #(.LATENCY(3)) u_l3 (
    .clk        (clk),
    .reset      (rst),
    .readM      (rd),
    .writeM     (wr),
    .address    (addr),
    .data       (bus1),
    .inputReady (ir[1]),
    .ackOutput  (ack[1]),
    .load_en    (le),
    .load_addr  (la),
    .load_data  (ld),
    .proto_err  (pe[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat [2] = '{1, 3};

  // Model: a request accepted at cycle t completes at t+lat
  // if its line stays high; then waits for release.
  bit          pend   [2];
  bit          pulse  [2];
  bit          hold   [2];
  bit          opw    [2];
  bit          perr_m [2];
  int          acc    [2];
  logic [7:0]  idx    [2];
  logic [15:0] wd     [2];
  logic [15:0] mm     [2][256];
  bit          mv     [2][256];

  function automatic logic [15:0] busv(int k);
    return (k == 0) ? bus0 : bus1;
  endfunction

  task automatic chk(string name, logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_clear(int k);
    pend[k]   = 0;
    pulse[k]  = 0;
    hold[k]   = 0;
    perr_m[k] = 0;
  endtask

  task automatic model_step(int k);
    bit line;
    line = opw[k] ? wr : rd;
    if (rst) begin
      model_clear(k);
    end else if (pulse[k]) begin
      if (opw[k]) begin
        mm[k][idx[k]] = wd[k];
        mv[k][idx[k]] = 1;
      end
      pulse[k] = 0;
      hold[k]  = 1;
    end else if (hold[k]) begin
      if (!line) hold[k] = 0;
    end else if (pend[k]) begin
      if (!line) begin
        pend[k] = 0;
      end else if (cyc == acc[k] + lat[k]) begin
        pend[k]  = 0;
        pulse[k] = 1;
      end
    end else begin
      if (le) begin
        mm[k][la[7:0]] = ld;
        mv[k][la[7:0]] = 1;
      end
      if (rd || wr) begin
        pend[k] = 1;
        acc[k]  = cyc;
        opw[k]  = !rd;
        idx[k]  = addr[7:0];
        wd[k]   = wdata;
        if (rd && wr) perr_m[k] = 1;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("inputReady%0d", k), 16'(ir[k]),
          16'(pulse[k] && !opw[k]));
      chk($sformatf("ackOutput%0d", k), 16'(ack[k]),
          16'(pulse[k] && opw[k]));
      chk($sformatf("proto_err%0d", k), 16'(pe[k]),
          16'(perr_m[k]));
      if (pulse[k] && !opw[k] && mv[k][idx[k]])
        chk($sformatf("rdata%0d", k), busv(k), mm[k][idx[k]]);
      if (wr && !rd && !ir[k])
        chk($sformatf("bus_wdata%0d", k), busv(k), wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    compare();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_clear(0);
    model_clear(1);
    #1;
    compare();
  endtask

  task automatic req(bit r, bit w, logic [15:0] a,
                     logic [15:0] d);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  logic [15:0] pre_a [6] = '{16'h0010, 16'h0005, 16'h0030,
                             16'h0040, 16'h0020, 16'h0105};
  logic [15:0] pre_d [6] = '{16'hBEEF, 16'hA5A5, 16'h0000,
                             16'h4040, 16'h0000, 16'hA5A5};

  initial begin
    rst = 1'b1;
    req(0, 0, 16'h0, 16'h0);
    le = 0;
    la = '0;
    ld = '0;
    tick();
    tick();
    chk("reset_ready", 16'(ir), 16'h0);
    chk("reset_proto", 16'(pe), 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      le = 1;
      la = pre_a[i];
      ld = pre_d[i];
      tick();
    end
    le = 0;

    // Read 0x10: L=1 pulses at t+1, L=3 at t+3.
    req(1, 0, 16'h0010, 16'h0);
    tick();
    chk("rd_l1_t0", 16'(ir[0]), 16'h0);
    tick();
    chk("rd_l1_t1", 16'(ir[0]), 16'h1);
    chk("rd_l1_data", bus0, 16'hBEEF);
    tick();
    chk("rd_l1_t2", 16'(ir[0]), 16'h0);
    chk("rd_l3_t2", 16'(ir[1]), 16'h0);
    tick();
    chk("rd_l3_t3", 16'(ir[1]), 16'h1);
    chk("rd_l3_data", bus1, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_held_nopulse", 16'(ir), 16'h0);
    end
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // Write 0x20 <= 0x1234, then read it back.
    req(0, 1, 16'h0020, 16'h1234);
    tick();
    tick();
    chk("wr_l1_ack", 16'(ack[0]), 16'h1);
    chk("wr_l1_noready", 16'(ir[0]), 16'h0);
    tick();
    chk("wr_l1_ack_end", 16'(ack[0]), 16'h0);
    tick();
    chk("wr_l3_ack", 16'(ack[1]), 16'h1);
    chk("wr_l3_bus", bus1, 16'h1234);
    tick();
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();
    req(1, 0, 16'h0020, 16'h0);
    tick();
    tick();
    chk("rb_l1_data", bus0, 16'h1234);
    tick();
    tick();
    chk("rb_l3_data", bus1, 16'h1234);
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // Upper address bits alias onto the same word.
    req(1, 0, 16'h0105, 16'h0);
    tick();
    tick();
    chk("wrap_l1", bus0, 16'hA5A5);
    tick();
    tick();
    chk("wrap_l3", bus1, 16'hA5A5);
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // Request dropped before completion: no pulse.
    req(1, 0, 16'h0010, 16'h0);
    tick();
    req(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_nopulse", 16'(ir), 16'h0);
    end

    // Reset while a write is in flight.
    req(0, 1, 16'h0030, 16'h7777);
    tick();
    tick();
    assert_rst();
    chk("rst_ack", 16'(ack), 16'h0);
    chk("rst_ready", 16'(ir), 16'h0);
    rst = 1'b0;
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();
    req(1, 0, 16'h0030, 16'h0);
    tick();
    tick();
    chk("rst_nocommit_l1", bus0, 16'h0000);
    tick();
    tick();
    chk("rst_nocommit_l3", bus1, 16'h0000);
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // Read and write together: read served, error sticky.
    req(1, 1, 16'h0040, 16'hDEAD);
    tick();
    chk("proto_set", 16'(pe), 16'h3);
    tick();
    tick();
    tick();
    chk("proto_l3_ready", 16'(ir[1]), 16'h1);
    chk("proto_l3_data", bus1, 16'h4040);
    req(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("proto_sticky", 16'(pe), 16'h3);
    req(1, 0, 16'h0040, 16'h0);
    tick();
    tick();
    chk("proto_mem_kept", bus0, 16'h4040);
    req(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    for (int n = 0; n < 4000; n++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(150) == 0) assert_rst();
      if ($urandom_range(5) == 0) begin
        int m;
        m = $urandom_range(9);
        req(m < 4 || m == 8,
            (m >= 4 && m < 8) || m == 8,
            {8'($urandom), 4'h0, 4'($urandom)},
            16'($urandom));
      end
      le = ($urandom_range(9) == 0);
      la = {8'($urandom), 4'h0, 4'($urandom)};
      ld = 16'($urandom);
    end
    rst = 1'b0;
    le  = 0;
    req(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
